// File: rtl/riscv_chk_pkg.sv
// Shared types for the RISC-V run-time result checker.
// State encoding, failure codes and the checkpoint table entry.
package riscv_chk_pkg;

  localparam int CHK_IW = 32;
  localparam int CHK_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_MISMATCH = 3'd1;
  localparam logic [2:0] FC_SKIP     = 3'd2;
  localparam logic [2:0] FC_EARLY    = 3'd3;
  localparam logic [2:0] FC_TIMEOUT  = 3'd4;

  // Table fields are stored at 32 bits; core widths up to 32 fit.
  typedef struct packed {
    logic [CHK_IW-1:0] ninst;
    logic [CHK_DW-1:0] ans;
    logic [CHK_DW-1:0] mask;
  } chk_entry_t;

  function automatic logic masked_eq(
    input logic [CHK_DW-1:0] got,
    input logic [CHK_DW-1:0] ans,
    input logic [CHK_DW-1:0] mask
  );
    return ((got ^ ans) & mask) == '0;
  endfunction

endpackage

// File: rtl/riscv_result_checker_table.sv
// Checkpoint table: register array, synchronous write,
// combinational read of the entry under the run pointer.
module chk_table
  import riscv_chk_pkg::*;
#(
  parameter int NUM_CHK = 32
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(NUM_CHK)-1:0] widx,
  input  chk_entry_t                 wdata,
  input  logic [$clog2(NUM_CHK)-1:0] ridx,
  output chk_entry_t                 rdata
);

  // Contents survive reset so a run can be repeated without reloading.
  chk_entry_t mem_q [NUM_CHK];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/riscv_result_checker.sv
// Table-driven run-time result checker for the RISC-V core.
// Compares OUTPUT_PORT at programmed instruction counts and grades the run.
module riscv_result_checker
  import riscv_chk_pkg::*;
#(
  parameter int NUM_CHK = 32,
  parameter int DWIDTH  = 32,
  parameter int IWIDTH  = 32,
  parameter int CWIDTH  = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CFG_WE,
  input  logic [$clog2(NUM_CHK)-1:0] CFG_IDX,
  input  logic [IWIDTH-1:0]          CFG_NINST,
  input  logic [DWIDTH-1:0]          CFG_ANS,
  input  logic [DWIDTH-1:0]          CFG_MASK,
  input  logic [$clog2(NUM_CHK):0]   CFG_COUNT,
  input  logic                       START,
  input  logic                       CONT_ON_FAIL,
  input  logic [IWIDTH-1:0]          NUM_INST,
  input  logic [DWIDTH-1:0]          OUTPUT_PORT,
  input  logic                       HALT,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       PASS,
  output logic [2:0]                 FAIL_CODE,
  output logic [$clog2(NUM_CHK)-1:0] FAIL_IDX,
  output logic [DWIDTH-1:0]          FAIL_GOT,
  output logic [$clog2(NUM_CHK):0]   PASS_CNT,
  output logic [$clog2(NUM_CHK):0]   FAIL_CNT,
  output logic [CWIDTH-1:0]          CYCLE
);

  localparam int IW = $clog2(NUM_CHK);
  localparam int NW = IW + 1;
  localparam logic [NW-1:0] MAX_CNT = NW'(NUM_CHK);
  localparam logic [CWIDTH-1:0] TMO_LAST = CWIDTH'(TIMEOUT - 1);

  chk_state_e        state_q, state_d;
  logic [NW-1:0]     ptr_q, ptr_d;
  logic [NW-1:0]     count_q, count_d;
  logic              cont_q, cont_d;
  logic [CWIDTH-1:0] cycle_q, cycle_d;
  logic [NW-1:0]     pass_cnt_q, pass_cnt_d;
  logic [NW-1:0]     fail_cnt_q, fail_cnt_d;
  logic [2:0]        fail_code_q, fail_code_d;
  logic [IW-1:0]     fail_idx_q, fail_idx_d;
  logic [DWIDTH-1:0] fail_got_q, fail_got_d;

  chk_entry_t    wr_ent;
  chk_entry_t    rd_ent;
  logic          tbl_we;
  logic [IW-1:0] rd_idx;

  logic          hit;
  logic          match;
  logic          skip;
  logic          ok;
  logic          chk_bad;
  logic          first_open;
  logic [2:0]    bad_code;
  logic [NW-1:0] cnt_in;

  assign wr_ent.ninst = CHK_IW'(CFG_NINST);
  assign wr_ent.ans   = CHK_DW'(CFG_ANS);
  assign wr_ent.mask  = CHK_DW'(CFG_MASK);
  assign tbl_we       = CFG_WE && (state_q == ST_IDLE);
  assign rd_idx       = ptr_q[IW-1:0];

  chk_table #(
    .NUM_CHK (NUM_CHK)
  ) u_table (
    .clk   (CLK),
    .we    (tbl_we),
    .widx  (CFG_IDX),
    .wdata (wr_ent),
    .ridx  (rd_idx),
    .rdata (rd_ent)
  );

  always_comb begin
    hit      = ptr_q < count_q;
    match    = hit && (NUM_INST == IWIDTH'(rd_ent.ninst));
    skip     = hit && (NUM_INST > IWIDTH'(rd_ent.ninst));
    ok       = masked_eq(CHK_DW'(OUTPUT_PORT), rd_ent.ans, rd_ent.mask);
    chk_bad  = (match && !ok) || skip;
    bad_code = skip ? FC_SKIP : FC_MISMATCH;
    cnt_in   = (CFG_COUNT > MAX_CNT) ? MAX_CNT : CFG_COUNT;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    cont_d      = cont_q;
    cycle_d     = cycle_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_code_d = fail_code_q;
    fail_idx_d  = fail_idx_q;
    fail_got_d  = fail_got_q;
    first_open  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        ptr_d      = ptr_q + NW'(match || skip);
        pass_cnt_d = pass_cnt_q + NW'(match && ok);
        fail_cnt_d = fail_cnt_q + NW'(chk_bad);

        if (chk_bad && (fail_code_q == FC_NONE)) begin
          fail_code_d = bad_code;
          fail_idx_d  = ptr_q[IW-1:0];
          fail_got_d  = OUTPUT_PORT;
        end
        first_open = (fail_code_q == FC_NONE) && !chk_bad;

        if (HALT) begin
          if (ptr_d < count_q) begin
            state_d = ST_FAIL;
            if (first_open) begin
              fail_code_d = FC_EARLY;
              fail_idx_d  = ptr_d[IW-1:0];
              fail_got_d  = OUTPUT_PORT;
            end
          end else if (fail_cnt_d == '0) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (chk_bad && !cont_q) begin
          state_d = ST_FAIL;
        end else if (cycle_q == TMO_LAST) begin
          state_d = ST_FAIL;
          if (first_open) begin
            fail_code_d = FC_TIMEOUT;
            fail_idx_d  = ptr_d[IW-1:0];
            fail_got_d  = OUTPUT_PORT;
          end
        end

        // CYCLE freezes on the deciding cycle.
        if ((state_d == ST_RUN) && (cycle_q != '1)) begin
          cycle_d = cycle_q + 1'b1;
        end
      end
      default: begin
        if (START) begin
          state_d     = ST_RUN;
          ptr_d       = '0;
          count_d     = cnt_in;
          cont_d      = CONT_ON_FAIL;
          cycle_d     = '0;
          pass_cnt_d  = '0;
          fail_cnt_d  = '0;
          fail_code_d = FC_NONE;
          fail_idx_d  = '0;
          fail_got_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      cont_q      <= 1'b0;
      cycle_q     <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      fail_code_q <= FC_NONE;
      fail_idx_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      cont_q      <= cont_d;
      cycle_q     <= cycle_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_code_q <= fail_code_d;
      fail_idx_q  <= fail_idx_d;
      fail_got_q  <= fail_got_d;
    end
  end

  assign BUSY      = (state_q == ST_RUN);
  assign DONE      = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign PASS      = (state_q == ST_PASS);
  assign FAIL_CODE = fail_code_q;
  assign FAIL_IDX  = fail_idx_q;
  assign FAIL_GOT  = fail_got_q;
  assign PASS_CNT  = pass_cnt_q;
  assign FAIL_CNT  = fail_cnt_q;
  assign CYCLE     = cycle_q;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Directed bench for riscv_result_checker with a verdict scoreboard.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_riscv_result_checker;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CFG_WE;
  logic [4:0]  CFG_IDX;
  logic [31:0] CFG_NINST;
  logic [31:0] CFG_ANS;
  logic [31:0] CFG_MASK;
  logic [5:0]  CFG_COUNT;
  logic        START;
  logic        CONT_ON_FAIL;
  logic [31:0] NUM_INST;
  logic [31:0] OUTPUT_PORT;
  logic        HALT;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [2:0]  FAIL_CODE;
  logic [4:0]  FAIL_IDX;
  logic [31:0] FAIL_GOT;
  logic [5:0]  PASS_CNT;
  logic [5:0]  FAIL_CNT;
  logic [31:0] CYCLE;

  always #5 CLK = ~CLK;

  riscv_result_checker #(
    .NUM_CHK (32),
    .DWIDTH  (32),
    .IWIDTH  (32),
    .CWIDTH  (32),
    .TIMEOUT (50)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CFG_WE       (CFG_WE),
    .CFG_IDX      (CFG_IDX),
    .CFG_NINST    (CFG_NINST),
    .CFG_ANS      (CFG_ANS),
    .CFG_MASK     (CFG_MASK),
    .CFG_COUNT    (CFG_COUNT),
    .START        (START),
    .CONT_ON_FAIL (CONT_ON_FAIL),
    .NUM_INST     (NUM_INST),
    .OUTPUT_PORT  (OUTPUT_PORT),
    .HALT         (HALT),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .PASS         (PASS),
    .FAIL_CODE    (FAIL_CODE),
    .FAIL_IDX     (FAIL_IDX),
    .FAIL_GOT     (FAIL_GOT),
    .PASS_CNT     (PASS_CNT),
    .FAIL_CNT     (FAIL_CNT),
    .CYCLE        (CYCLE)
  );

  typedef struct {
    logic        pass;
    logic [2:0]  code;
    logic [4:0]  idx;
    logic [31:0] got;
    logic [5:0]  pcnt;
    logic [5:0]  fcnt;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input logic pass, input logic [2:0] code,
                            input logic [4:0] idx, input logic [31:0] got,
                            input logic [5:0] pcnt, input logic [5:0] fcnt,
                            input logic [31:0] cyc);
    exp_t e;
    e.pass = pass;
    e.code = code;
    e.idx  = idx;
    e.got  = got;
    e.pcnt = pcnt;
    e.fcnt = fcnt;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic [31:0] n, input logic [31:0] o,
                     input logic h);
    NUM_INST    = n;
    OUTPUT_PORT = o;
    HALT        = h;
    @(negedge CLK);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] ninst,
                    input logic [31:0] ans, input logic [31:0] mask);
    CFG_WE    = 1'b1;
    CFG_IDX   = idx;
    CFG_NINST = ninst;
    CFG_ANS   = ans;
    CFG_MASK  = mask;
    @(negedge CLK);
    CFG_WE    = 1'b0;
  endtask

  task automatic start(input logic [5:0] cnt, input logic cont);
    NUM_INST     = '0;
    OUTPUT_PORT  = '0;
    HALT         = 1'b0;
    START        = 1'b1;
    CFG_COUNT    = cnt;
    CONT_ON_FAIL = cont;
    @(negedge CLK);
    START        = 1'b0;
  endtask

  task automatic verdict(input string tag);
    exp_t e;
    check({tag, ".done"}, 32'(DONE), 32'd1);
    check({tag, ".busy"}, 32'(BUSY), 32'd0);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed DONE %0b", tag, DONE);
    end else begin
      e = sb.pop_front();
      check({tag, ".pass"}, 32'(PASS), 32'(e.pass));
      check({tag, ".code"}, 32'(FAIL_CODE), 32'(e.code));
      check({tag, ".idx"}, 32'(FAIL_IDX), 32'(e.idx));
      check({tag, ".got"}, FAIL_GOT, e.got);
      check({tag, ".pcnt"}, 32'(PASS_CNT), 32'(e.pcnt));
      check({tag, ".fcnt"}, 32'(FAIL_CNT), 32'(e.fcnt));
      check({tag, ".cycle"}, CYCLE, e.cyc);
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    for (int i = 0; i < max && !DONE; i++) @(negedge CLK);
    if (!DONE) begin
      checks++;
      errors++;
      $error("FAIL %s: DONE observed 0 after %0d cycles, expected 1",
             tag, max);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"}, 32'(BUSY), 32'd0);
    check({tag, ".done"}, 32'(DONE), 32'd0);
    check({tag, ".pass"}, 32'(PASS), 32'd0);
    check({tag, ".code"}, 32'(FAIL_CODE), 32'd0);
    check({tag, ".idx"}, 32'(FAIL_IDX), 32'd0);
    check({tag, ".got"}, FAIL_GOT, 32'd0);
    check({tag, ".pcnt"}, 32'(PASS_CNT), 32'd0);
    check({tag, ".fcnt"}, 32'(FAIL_CNT), 32'd0);
    check({tag, ".cycle"}, CYCLE, 32'd0);
  endtask

  initial begin
    RST          = 1'b1;
    CFG_WE       = 1'b0;
    CFG_IDX      = '0;
    CFG_NINST    = '0;
    CFG_ANS      = '0;
    CFG_MASK     = '0;
    CFG_COUNT    = '0;
    START        = 1'b0;
    CONT_ON_FAIL = 1'b0;
    NUM_INST     = '0;
    OUTPUT_PORT  = '0;
    HALT         = 1'b0;
    repeat (2) @(negedge CLK);
    check_zero("reset");
    RST = 1'b0;
    @(negedge CLK);

    wr(5'd0, 32'd1, 32'h0, 32'hFFFF_FFFF);
    wr(5'd1, 32'd3, 32'h5, 32'hFFFF_FFFF);
    wr(5'd2, 32'd5, 32'h1, 32'hFFFF_FFFF);

    // mismatch at the last checkpoint, stop mode
    expect_run(1'b0, 3'd1, 5'd2, 32'h2, 6'd2, 6'd1, 32'd4);
    start(6'd3, 1'b0);
    cyc(32'd1, 32'h0, 1'b0);
    cyc(32'd2, 32'h0, 1'b0);
    cyc(32'd3, 32'h5, 1'b0);
    cyc(32'd4, 32'h5, 1'b0);
    check("mism.pre_done", 32'(DONE), 32'd0);
    cyc(32'd5, 32'h2, 1'b0);
    verdict("mism");

    // clean pass, restarted from FAIL
    expect_run(1'b1, 3'd0, 5'd0, 32'h0, 6'd3, 6'd0, 32'd5);
    start(6'd3, 1'b0);
    cyc(32'd1, 32'h0, 1'b0);
    cyc(32'd2, 32'h7, 1'b0);
    cyc(32'd3, 32'h5, 1'b0);
    cyc(32'd4, 32'h7, 1'b0);
    cyc(32'd5, 32'h1, 1'b0);
    cyc(32'd5, 32'h1, 1'b1);
    verdict("clean");

    // skipped checkpoint, continue mode
    expect_run(1'b0, 3'd2, 5'd1, 32'h9, 6'd2, 6'd1, 32'd3);
    start(6'd3, 1'b1);
    cyc(32'd1, 32'h0, 1'b0);
    cyc(32'd4, 32'h9, 1'b0);
    check("skip.busy", 32'(BUSY), 32'd1);
    check("skip.fcnt_mid", 32'(FAIL_CNT), 32'd1);
    cyc(32'd5, 32'h1, 1'b0);
    cyc(32'd5, 32'h1, 1'b1);
    verdict("skip");

    // early halt leaves the pointer on entry 2
    expect_run(1'b0, 3'd3, 5'd2, 32'h5, 6'd2, 6'd0, 32'd2);
    start(6'd3, 1'b0);
    cyc(32'd1, 32'h0, 1'b0);
    cyc(32'd2, 32'h0, 1'b0);
    cyc(32'd3, 32'h5, 1'b1);
    verdict("early");

    // table writes are ignored in FAIL
    wr(5'd0, 32'd1, 32'hDEAD, 32'hFFFF_FFFF);
    check("fail_hold.code", 32'(FAIL_CODE), 32'd3);

    // reset mid-run, then re-run on the retained table
    start(6'd3, 1'b0);
    cyc(32'd1, 32'h0, 1'b0);
    cyc(32'd2, 32'h0, 1'b0);
    check("abort.busy_pre", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    check_zero("abort");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    expect_run(1'b1, 3'd0, 5'd0, 32'h0, 6'd3, 6'd0, 32'd5);
    start(6'd3, 1'b0);
    cyc(32'd1, 32'h0, 1'b0);
    cyc(32'd2, 32'h3, 1'b0);
    cyc(32'd3, 32'h5, 1'b0);
    cyc(32'd4, 32'h3, 1'b0);
    cyc(32'd5, 32'h1, 1'b0);
    cyc(32'd5, 32'h1, 1'b1);
    verdict("rerun");

    // masked compare: only bits 7:4 are checked
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    wr(5'd0, 32'd2, 32'h0000_00F0, 32'h0000_00F0);
    expect_run(1'b1, 3'd0, 5'd0, 32'h0, 6'd1, 6'd0, 32'd2);
    start(6'd1, 1'b0);
    cyc(32'd1, 32'h0, 1'b0);
    cyc(32'd2, 32'h0000_ABF5, 1'b0);
    check("mask.pcnt_mid", 32'(PASS_CNT), 32'd1);
    cyc(32'd3, 32'h0, 1'b1);
    verdict("mask");

    // empty table passes on HALT alone
    expect_run(1'b1, 3'd0, 5'd0, 32'h0, 6'd0, 6'd0, 32'd0);
    start(6'd0, 1'b0);
    cyc(32'd0, 32'h0, 1'b1);
    verdict("cnt0");

    // timeout with no HALT
    expect_run(1'b0, 3'd4, 5'd0, 32'h0, 6'd0, 6'd0, 32'd49);
    start(6'd0, 1'b0);
    wait_done("tmo", 100);
    verdict("tmo");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
